// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect the BTNU pad
// for the mmio button register.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_raw     unsynchronised pad input
//   ack         one-cycle clear of btn_sticky from mmio
//   btn_level   debounced level
//   btn_press   one-cycle pulse per accepted press (and per repeat)
//   btn_sticky  set by btn_press, cleared by ack (set wins)
//   press_count btn_press pulses modulo 256
//
// Optional feature: define BTN_AUTOREPEAT_EN for hold-to-repeat pulses
// (adds REPEAT_DELAY / REPEAT_PERIOD parameters).
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_sticky,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } state_t;

  // The edge that enters a wait state already saw one stable s2
  // cycle, so the wait state itself needs DEBOUNCE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;
  logic             level_nxt;
  logic             sticky_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOW: begin
        if (s2) state_nxt = RISE_WAIT;
      end
      RISE_WAIT: begin
        if (!s2)
          state_nxt = LOW;
        else if (cnt == CNT_LAST)
          state_nxt = HIGH;
      end
      HIGH: begin
        if (!s2) state_nxt = FALL_WAIT;
      end
      FALL_WAIT: begin
        if (s2)
          state_nxt = HIGH;
        else if (cnt == CNT_LAST)
          state_nxt = LOW;
      end
      default: state_nxt = LOW;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX);
  // HIGH cycle 0 is the entry cycle; the first repeat must be
  // visible in cycle REPEAT_DELAY-1, so fire one count earlier.
  localparam logic [RPT_W-1:0] RPT_FIRST =
    RPT_W'(REPEAT_DELAY - 2);
  localparam logic [RPT_W-1:0] RPT_NEXT =
    RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_nxt;
  logic             rpt_arm;
  logic             rpt_arm_nxt;
  logic             rpt_fire;

  always_comb begin
    rpt_nxt     = '0;
    rpt_arm_nxt = 1'b0;
    rpt_fire    = 1'b0;
    if (state == HIGH && state_nxt == HIGH) begin
      if (rpt == (rpt_arm ? RPT_NEXT : RPT_FIRST)) begin
        rpt_fire    = 1'b1;
        rpt_arm_nxt = 1'b1;
      end else begin
        rpt_nxt     = rpt + 1'b1;
        rpt_arm_nxt = rpt_arm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt     <= '0;
      rpt_arm <= 1'b0;
    end else begin
      rpt     <= rpt_nxt;
      rpt_arm <= rpt_arm_nxt;
    end
  end
`else
  logic rpt_fire;
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    cnt_nxt = '0;
    if ((state == RISE_WAIT && state_nxt == RISE_WAIT) ||
        (state == FALL_WAIT && state_nxt == FALL_WAIT))
      cnt_nxt = cnt + 1'b1;
    level_nxt = (state_nxt == HIGH) ||
                (state_nxt == FALL_WAIT);
    press_nxt = (state == RISE_WAIT && state_nxt == HIGH) ||
                rpt_fire;
    // An ack seen while btn_press is high loses to that press.
    sticky_nxt = press_nxt |
                 (btn_sticky & ~(ack & ~btn_press));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_sticky  <= 1'b0;
      press_count <= 8'd0;
    end else begin
      cnt        <= cnt_nxt;
      btn_level  <= level_nxt;
      btn_press  <= press_nxt;
      btn_sticky <= sticky_nxt;
      if (press_nxt)
        press_count <= press_count + 8'd1;
    end
  end

endmodule
